multi_fifo_scoreboard: RTL and testbench

In-line magic-packet scoreboard for the shared linked-list multi-FIFO, generalised to track one packet per channel across all `NUM_FIFOS` channels concurrently. It snoops push/pop traffic and the shared FIFO's outputs, captures a tagged packet per channel, counts it down to the head, and checks `data_out` on the exact pop that removes it. It sits beside `linked_list_fifo` in the refinement-proof top and in simulation benches; it drives nothing back into the FIFO.

---
 rtl/multi_fifo_scoreboard.sv | 137 +++++++++++++
 tb/tb_multi_fifo_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_fifo_scoreboard.sv
// Per-channel magic-packet scoreboard that snoops a shared linked-list multi-FIFO.
// Optional environment checker enabled by defining SB_ENV_CHECK_EN.
module multi_fifo_scoreboard #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int NUM_FIFOS = 1,
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [SEL_WIDTH-1:0] push_sel,
  input  logic [SEL_WIDTH-1:0] pop_sel,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     data_out,
  input  logic                 full,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic                 start,
  output logic                 data_out_vld,
  output logic                 prop_signal,
  output logic [NUM_FIFOS-1:0] done,
  output logic [NUM_FIFOS-1:0] err,
  output logic                 env_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, DONE = 2'd2} state_t;

  logic [NUM_FIFOS-1:0]           push_c;
  logic [NUM_FIFOS-1:0]           pop_c;
  logic [NUM_FIFOS-1:0]           vld_c;
  logic [NUM_FIFOS-1:0]           mis_c;
  logic [NUM_FIFOS-1:0]           cnt_zero;
  logic [NUM_FIFOS*CNT_WIDTH-1:0] counts;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_ch
      localparam logic [SEL_WIDTH-1:0] CH = SEL_WIDTH'(gi);

      state_t               state_q, state_d;
      logic [CNT_WIDTH-1:0] count_q, count_d;
      logic [CNT_WIDTH-1:0] ahead_q, ahead_d;
      logic [WIDTH-1:0]     magic_q, magic_d;
      logic                 err_q, err_d;

      assign push_c[gi] = push && (push_sel == CH);
      assign pop_c[gi]  = pop && (pop_sel == CH);
      assign vld_c[gi]  = pop_c[gi] && (state_q == TRACK) && (ahead_q == '0);
      assign mis_c[gi]  = vld_c[gi] && (data_out != magic_q);

      always_comb begin
        state_d = state_q;
        ahead_d = ahead_q;
        magic_d = magic_q;
        err_d   = err_q | mis_c[gi];
        count_d = count_q + CNT_WIDTH'(push_c[gi]) - CNT_WIDTH'(pop_c[gi]);
        case (state_q)
          IDLE: begin
            if (start && push_c[gi]) begin
              state_d = TRACK;
              magic_d = data_in;
              // Entries still in front once this cycle's pop has left.
              ahead_d = count_q - CNT_WIDTH'(pop_c[gi]);
            end
          end
          TRACK: begin
            if (pop_c[gi]) begin
              if (ahead_q == '0) state_d = DONE;
              else               ahead_d = ahead_q - 1'b1;
            end
          end
          default: ;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= IDLE;
          count_q <= '0;
          ahead_q <= '0;
          err_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          count_q <= count_d;
          ahead_q <= ahead_d;
          err_q   <= err_d;
        end
      end

      // Magic value is only meaningful in TRACK, so it carries no reset.
      always_ff @(posedge clk) magic_q <= magic_d;

      assign done[gi]                           = (state_q == DONE);
      assign err[gi]                            = err_q;
      assign cnt_zero[gi]                       = (count_q == '0);
      assign counts[gi*CNT_WIDTH +: CNT_WIDTH]  = count_q;
    end
  endgenerate

  // At most one channel pops per cycle, so at most one mismatch bit is live.
  assign data_out_vld = |vld_c;
  assign prop_signal  = ~(|mis_c);

`ifdef SB_ENV_CHECK_EN
  logic [31:0] cnt_sum;
  logic        env_viol;
  logic        env_err_q, env_err_d;

  always_comb begin
    cnt_sum = '0;
    for (int c = 0; c < NUM_FIFOS; c++) begin
      cnt_sum = cnt_sum + 32'(counts[c*CNT_WIDTH +: CNT_WIDTH]);
    end
    env_viol  = (push && full) ||
                (|(pop_c & empty)) ||
                (push && !(|push_c)) ||
                (pop && !(|pop_c)) ||
                (cnt_sum > 32'(DEPTH)) ||
                (|(empty ^ cnt_zero));
    env_err_d = env_err_q | env_viol;
  end

  always_ff @(posedge clk) begin
    if (rst) env_err_q <= 1'b0;
    else     env_err_q <= env_err_d;
  end

  assign env_err = env_err_q;
`else
  logic unused_env;
  assign unused_env = ^{full, empty, counts, cnt_zero};
  assign env_err    = 1'b0;
`endif

endmodule

// File: tb/tb_multi_fifo_scoreboard.sv
// Directed bench for multi_fifo_scoreboard: a queue-based reference FIFO model
// predicts every output each cycle, plus literal checks from hand-worked scenarios.
module tb_multi_fifo_scoreboard;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int SW = 1;

  logic          clk = 1'b0;
  logic          rst, push, pop, start, full;
  logic [SW-1:0] push_sel, pop_sel;
  logic [W-1:0]  data_in, data_out;
  logic [N-1:0]  empty;
  logic          data_out_vld, prop_signal, env_err;
  logic [N-1:0]  done, err;

  multi_fifo_scoreboard #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(N)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .push_sel(push_sel), .pop_sel(pop_sel),
    .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty), .start(start),
    .data_out_vld(data_out_vld), .prop_signal(prop_signal),
    .done(done), .err(err), .env_err(env_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: each channel is a FIFO of (data, is_magic) entries.
  logic [W-1:0] md [N][8];
  bit           mm [N][8];
  int           msz [N];
  bit           mtrk [N];
  bit           mdone [N];
  bit           merr [N];
  logic [W-1:0] mmagic [N];
  bit           menv;
  bit           chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model as the next edge will.
  initial forever begin
    int  s;
    bit  exp_vld, exp_prop, mk;
    @(negedge clk);
    s = int'(pop_sel);
    if (chk_en) begin
      exp_vld  = pop && (msz[s] > 0) && mm[s][0];
      exp_prop = !exp_vld || (data_out == mmagic[s]);
      check("model_vld",  {31'd0, data_out_vld}, {31'd0, exp_vld});
      check("model_prop", {31'd0, prop_signal},  {31'd0, exp_prop});
      check("model_done", {30'd0, done},         {30'd0, mdone[1], mdone[0]});
      check("model_err",  {30'd0, err},          {30'd0, merr[1], merr[0]});
      check("model_env",  {31'd0, env_err},      {31'd0, menv});
    end
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        msz[c] = 0; mtrk[c] = 0; mdone[c] = 0; merr[c] = 0;
      end
      menv = 0;
    end else begin
`ifdef SB_ENV_CHECK_EN
      if ((push && full) || (pop && empty[s]) || (msz[0] + msz[1] > D)) menv = 1;
`endif
      if (pop && msz[s] > 0) begin
        if (mm[s][0]) begin
          mdone[s] = 1;
          mtrk[s]  = 0;
          if (data_out != mmagic[s]) merr[s] = 1;
        end
        for (int i = 0; i < 7; i++) begin
          md[s][i] = md[s][i+1];
          mm[s][i] = mm[s][i+1];
        end
        msz[s]--;
      end
      if (push) begin
        s  = int'(push_sel);
        mk = start && !mtrk[s] && !mdone[s];
        if (mk) begin
          mtrk[s]   = 1;
          mmagic[s] = data_in;
        end
        md[s][msz[s]] = data_in;
        mm[s][msz[s]] = mk;
        msz[s]++;
      end
    end
  end

  task automatic drive(input bit ps, input int psel, input logic [W-1:0] din, input bit st,
                       input bit pp, input int osel, input int ovr);
    push     = ps;
    push_sel = psel[SW-1:0];
    data_in  = din;
    start    = st;
    pop      = pp;
    pop_sel  = osel[SW-1:0];
    if (ovr >= 0)                data_out = ovr[W-1:0];
    else if (pp && msz[osel] > 0) data_out = md[osel][0];
    else                         data_out = '0;
    empty = {msz[1] == 0, msz[0] == 0};
    full  = (msz[0] + msz[1]) >= D;
    $display("t=%0t rst=%0b push=%0b/%0d din=%02h start=%0b pop=%0b/%0d dout=%02h", $time,
             rst, ps, psel, din, st, pp, osel, data_out);
  endtask

  // One clock of stimulus; lit_vld/lit_prop < 0 means no literal expectation.
  task automatic cyc(input bit ps, input int psel, input logic [W-1:0] din, input bit st,
                     input bit pp, input int osel, input int ovr, input int lit_vld,
                     input int lit_prop);
    drive(ps, psel, din, st, pp, osel, ovr);
    @(negedge clk);
    if (lit_vld >= 0)  check("lit_vld",  {31'd0, data_out_vld}, lit_vld);
    if (lit_prop >= 0) check("lit_prop", {31'd0, prop_signal},  lit_prop);
    @(posedge clk); #1;
  endtask

  task automatic pushc(input int ch, input logic [W-1:0] d, input bit st);
    cyc(1, ch, d, st, 0, 0, -1, -1, -1);
  endtask

  task automatic popc(input int ch, input int lit_vld);
    cyc(0, 0, 8'h00, 0, 1, ch, -1, lit_vld, 1);
  endtask

  task automatic idle_chk(input logic [1:0] ed, input logic [1:0] ee, input logic een);
    drive(0, 0, 8'h00, 0, 0, 0, -1);
    @(negedge clk);
    check("lit_done", {30'd0, done},    {30'd0, ed});
    check("lit_err",  {30'd0, err},     {30'd0, ee});
    check("lit_env",  {31'd0, env_err}, {31'd0, een});
    @(posedge clk); #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0, -1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0, -1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    drive(1, 0, 8'hEE, 1, 0, 0, -1);
    @(negedge clk);
    check("rst_vld",  {31'd0, data_out_vld}, 32'd0);
    check("rst_prop", {31'd0, prop_signal},  32'd1);
    check("rst_done", {30'd0, done},         32'd0);
    check("rst_err",  {30'd0, err},          32'd0);
    check("rst_env",  {31'd0, env_err},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Magic packet third in ch0, exits on the third pop.
    pushc(0, 8'h11, 0);
    pushc(0, 8'h22, 0);
    pushc(0, 8'h33, 1);
    popc(0, 0);
    popc(0, 0);
    popc(0, 1);
    idle_chk(2'b01, 2'b00, 1'b0);
    reset_cycle();

    // Same, with a corrupted head value on the magic pop.
    pushc(0, 8'h11, 0);
    pushc(0, 8'h22, 0);
    pushc(0, 8'h33, 1);
    popc(0, 0);
    popc(0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0, 8'h34, 1, 0);
    idle_chk(2'b01, 2'b01, 1'b0);
    idle_chk(2'b01, 2'b01, 1'b0);
    reset_cycle();
    idle_chk(2'b00, 2'b00, 1'b0);

    // Both channels tracking concurrently.
    pushc(1, 8'hA5, 1);
    pushc(0, 8'h5A, 1);
    pushc(1, 8'h10, 1);
    popc(1, 1);
    popc(0, 1);
    popc(1, 0);
    idle_chk(2'b11, 2'b00, 1'b0);
    reset_cycle();

    // Start push coinciding with a pop on the same channel.
    pushc(0, 8'h01, 0);
    pushc(0, 8'h02, 0);
    cyc(1, 0, 8'h77, 1, 1, 0, -1, 0, 1);
    popc(0, 0);
    popc(0, 1);
    idle_chk(2'b01, 2'b00, 1'b0);
    reset_cycle();

    // Reset in the middle of tracking aborts it.
    pushc(0, 8'h01, 0);
    pushc(0, 8'h42, 1);
    popc(0, 0);
    reset_cycle();
    pushc(0, 8'h09, 0);
    popc(0, 0);
    idle_chk(2'b00, 2'b00, 1'b0);
    pushc(0, 8'h55, 1);
    popc(0, 1);
    idle_chk(2'b01, 2'b00, 1'b0);
    reset_cycle();

    // Pop of an empty channel: environment violation when the checker exists.
    popc(1, 0);
`ifdef SB_ENV_CHECK_EN
    idle_chk(2'b00, 2'b00, 1'b1);
    idle_chk(2'b00, 2'b00, 1'b1);
`else
    idle_chk(2'b00, 2'b00, 1'b0);
    idle_chk(2'b00, 2'b00, 1'b0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
